mmul_loader: RTL and testbench

Memory-to-FIFO loader for the matrix-vector multiplier. On a start pulse it fetches M rows of matrix A and one B vector from a word-addressed memory interface (one row of N elements per word). It unpacks each word into N elements and pushes them one per cycle into the M per-row A FIFOs and the single B FIFO that the multiplier drains. When every element is written it pulses done; that pulse drives the multiplier's enable.

---
 rtl/mmul_pkg.sv | 21 ++
 rtl/mmul_row_unpacker.sv | 39 +++
 rtl/mmul_loader.sv | 138 +++++++++++++
 tb/tb_mmul_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmul_pkg.sv
// Shared types and default sizes for the matrix-vector multiplier and its loader.
package mmul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int MMUL_DATA_WIDTH = 8;
  localparam int MMUL_N          = 8;
  localparam int MMUL_M          = 8;

  // Counter width for a count that runs 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmul_row_unpacker.sv
// Holds one fetched row word and hands out its elements MSB-first, one per advance.
module mmul_row_unpacker
  import mmul_pkg::*;
#(
  parameter int DATA_WIDTH = MMUL_DATA_WIDTH,
  parameter int N          = MMUL_N
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic                    i_advance,
  input  logic [DATA_WIDTH*N-1:0] i_word,
  output logic [DATA_WIDTH-1:0]   o_elem,
  output logic                    o_last
);

  localparam int EW = cnt_width(N);

  logic [DATA_WIDTH*N-1:0] word_p0;
  logic [EW-1:0]           elem_p0;

  // Load a whole row, then shift left one element per advance so the current element is always at the top.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_p0 <= '0;
      elem_p0 <= '0;
    end else if (i_load) begin
      word_p0 <= i_word;
      elem_p0 <= '0;
    end else if (i_advance) begin
      word_p0 <= word_p0 << DATA_WIDTH;
      elem_p0 <= elem_p0 + 1'b1;
    end
  end

  assign o_elem = word_p0[DATA_WIDTH*N-1 -: DATA_WIDTH];
  assign o_last = (elem_p0 == EW'(N - 1));

endmodule

// File: rtl/mmul_loader.sv
// Fetches M matrix rows plus one vector row from memory and streams their elements
// into the per-row A FIFOs and the B FIFO, then pulses o_done.
// Optional build macro MMUL_LOADER_PERF_EN adds the o_stall_cycles counter port.
module mmul_loader
  import mmul_pkg::*;
#(
  parameter int DATA_WIDTH = MMUL_DATA_WIDTH,
  parameter int N          = MMUL_N,
  parameter int M          = MMUL_M,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [ADDR_WIDTH-1:0]   o_address,
  output logic                    o_read,
  input  logic                    i_waitrequest,
  input  logic [DATA_WIDTH*N-1:0] i_readdata,
  input  logic                    i_readdatavalid,
  output logic                    o_a_wren [M],
  input  logic                    i_a_full [M],
  output logic                    o_b_wren,
  input  logic                    i_b_full,
  output logic [DATA_WIDTH-1:0]   o_wdata
`ifdef MMUL_LOADER_PERF_EN
  ,
  output logic [31:0]             o_stall_cycles
`endif
);

  localparam int RW = $clog2(M + 1);

  state_t                  state_p0, state_nx;
  logic [ADDR_WIDTH-1:0]   addr_p0;
  logic [RW-1:0]           row_p0;
  logic                    last_row;
  logic                    tgt_full;
  logic                    wr_fire;
  logic                    rd_load;
  logic                    elem_last;
  logic [DATA_WIDTH-1:0]   elem;

  assign last_row = (row_p0 == RW'(M));
  assign wr_fire  = (state_p0 == WRITE) && !tgt_full;
  assign rd_load  = (state_p0 == WAIT) && i_readdatavalid;

  // Full flag of the FIFO that the current row feeds (row M is the B vector).
  always_comb begin
    tgt_full = i_b_full;
    for (int i = 0; i < M; i++)
      if (row_p0 == RW'(i)) tgt_full = i_a_full[i];
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_p0 <= IDLE;
    else       state_p0 <= state_nx;
  end

  // Next-state decode; a single outstanding read per row.
  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      IDLE:    if (i_start) state_nx = REQ;
      REQ:     if (!i_waitrequest) state_nx = WAIT;
      WAIT:    if (i_readdatavalid) state_nx = WRITE;
      WRITE:   if (wr_fire && elem_last) state_nx = last_row ? DONE : REQ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Row index and read address; address arithmetic wraps at ADDR_WIDTH bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_p0 <= '0;
      row_p0  <= '0;
    end else if (state_p0 == IDLE && i_start) begin
      addr_p0 <= i_base_addr;
      row_p0  <= '0;
    end else if (wr_fire && elem_last && !last_row) begin
      addr_p0 <= addr_p0 + 1'b1;
      row_p0  <= row_p0 + 1'b1;
    end
  end

  mmul_row_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N)
  ) u_unpacker (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (rd_load),
    .i_advance (wr_fire),
    .i_word    (i_readdata),
    .o_elem    (elem),
    .o_last    (elem_last)
  );

  assign o_busy    = (state_p0 != IDLE);
  assign o_done    = (state_p0 == DONE);
  assign o_read    = (state_p0 == REQ);
  assign o_address = addr_p0;
  assign o_wdata   = elem;
  assign o_b_wren  = wr_fire && last_row;

  // One-hot write enable toward the A FIFO selected by the current row.
  always_comb begin
    for (int i = 0; i < M; i++)
      o_a_wren[i] = wr_fire && (row_p0 == RW'(i));
  end

`ifdef MMUL_LOADER_PERF_EN
  logic [31:0] stall_p0;
  logic        stall_cyc;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign stall_cyc = ((state_p0 == REQ)   && i_waitrequest)    ||
                     ((state_p0 == WAIT)  && !i_readdatavalid) ||
                     ((state_p0 == WRITE) && tgt_full);

  // Saturating stall counter, cleared by an accepted start and frozen while idle.
  always_ff @(posedge i_clk) begin
    if (i_rst)                             stall_p0 <= '0;
    else if (state_p0 == IDLE && i_start)  stall_p0 <= '0;
    else if (stall_cyc)                    stall_p0 <= sat_inc(stall_p0);
  end

  assign o_stall_cycles = stall_p0;
`endif

endmodule

// File: tb/tb_mmul_loader.sv
// Self-checking bench for mmul_loader: vector table, multi-cycle corner sequences, random loads.
module tb_mmul_loader;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int M  = 8;
  localparam int AW = 32;
  localparam int WW = DW * N;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, read, waitreq, rdv, b_wren, b_full;
  logic [AW-1:0] base, address;
  logic [WW-1:0] rdata;
  logic [DW-1:0] wdata;
  logic          a_wren [M];
  logic          a_full [M];
`ifdef MMUL_LOADER_PERF_EN
  logic [31:0]   stall_cycles, w_stall;
`endif

  // narrow-address instance for the wrap check
  logic          w_start, w_busy, w_done, w_read, w_waitreq, w_rdv, w_b_wren, w_b_full;
  logic [3:0]    w_base, w_address;
  logic [WW-1:0] w_rdata;
  logic [DW-1:0] w_wdata;
  logic          w_a_wren [M];
  logic          w_a_full [M];

  always #5 clk = ~clk;

  mmul_loader #(.DATA_WIDTH(DW), .N(N), .M(M), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base),
    .o_busy(busy), .o_done(done), .o_address(address), .o_read(read),
    .i_waitrequest(waitreq), .i_readdata(rdata), .i_readdatavalid(rdv),
    .o_a_wren(a_wren), .i_a_full(a_full), .o_b_wren(b_wren), .i_b_full(b_full),
    .o_wdata(wdata)
`ifdef MMUL_LOADER_PERF_EN
    , .o_stall_cycles(stall_cycles)
`endif
  );

  mmul_loader #(.DATA_WIDTH(DW), .N(N), .M(M), .ADDR_WIDTH(4)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_start(w_start), .i_base_addr(w_base),
    .o_busy(w_busy), .o_done(w_done), .o_address(w_address), .o_read(w_read),
    .i_waitrequest(w_waitreq), .i_readdata(w_rdata), .i_readdatavalid(w_rdv),
    .o_a_wren(w_a_wren), .i_a_full(w_a_full), .o_b_wren(w_b_wren), .i_b_full(w_b_full),
    .o_wdata(w_wdata)
`ifdef MMUL_LOADER_PERF_EN
    , .o_stall_cycles(w_stall)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [WW-1:0] mem [logic [AW-1:0]];

  // environment knobs
  int lat = 1, rand_wait_pct = 0, rand_full_pct = 0;
  bit wait_addr_en = 0;
  logic [AW-1:0] wait_addr;
  int wait_left = 0, full_row = -1, full_len = 0, full_left = 0;
  bit full_trig_done = 0, inject_rdv = 0;

  // memory + observation state
  int mcnt = 0;
  logic [AW-1:0] mlat_addr;
  logic [DW-1:0] got_a [M][$];
  logic [DW-1:0] got_b [$];
  logic [DW-1:0] hold_q [$];
  logic [AW-1:0] got_addr [$];
  logic [3:0]    w_addrs [$];
  int done_cnt, done_cyc, viol, multi_wren, stall_obs, wren_total, cur_row, wr_left;
  int w_done_cnt, w_wren, nw;
  bit done_busy, outstanding, prev_stalled, tf, w_pend;
  logic [AW-1:0] prev_addr;

  typedef struct {
    logic [AW-1:0] base;
    int lat, wait_row, wait_len, full_row, full_len;
    int exp_cycles, exp_stall;
  } vec_t;
  vec_t tbl [5];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WW-1:0] word_at(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive memory/FIFO inputs at the falling edge, then observe the settled outputs.
  always @(negedge clk) begin
    rdv   = 1'b0;
    rdata = {$urandom, $urandom};
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin rdv = 1'b1; rdata = word_at(mlat_addr); end
    end
    if (inject_rdv) begin rdv = 1'b1; inject_rdv = 0; end
    if (wait_addr_en && read && address == wait_addr && wait_left > 0) begin
      waitreq = 1'b1; wait_left--;
    end else waitreq = ($urandom_range(99) < rand_wait_pct);
    for (int i = 0; i < M; i++) a_full[i] = ($urandom_range(99) < rand_full_pct);
    b_full = ($urandom_range(99) < rand_full_pct);
    if (full_left > 0) begin a_full[full_row] = 1'b1; full_left--; end
    w_rdv = w_pend; w_pend = 0;
    #1;
    nw = b_wren ? 1 : 0;
    for (int i = 0; i < M; i++) if (a_wren[i]) nw++;
    if (nw > 1) multi_wren++;
    if (wr_left > 0) begin
      if (cur_row == M) tf = b_full; else tf = a_full[cur_row];
      if (nw == 0) begin stall_obs++; if (!tf) viol++; end
      else wr_left--;
    end else if (nw > 0) viol++;
    for (int i = 0; i < M; i++)
      if (a_wren[i]) begin got_a[i].push_back(wdata); if (a_full[i]) viol++; end
    if (b_wren) begin got_b.push_back(wdata); if (b_full) viol++; end
    if (full_row >= 0 && a_full[full_row]) hold_q.push_back(wdata);
    if (outstanding) begin
      if (rdv) begin outstanding = 0; wr_left = N; end
      else stall_obs++;
    end
    if (read && waitreq) stall_obs++;
    if (prev_stalled && (!read || address != prev_addr)) viol++;
    prev_stalled = read && waitreq;
    prev_addr    = address;
    if (read && !waitreq) begin
      if (outstanding) viol++;
      got_addr.push_back(address);
      cur_row = got_addr.size() - 1;
      mcnt = lat; mlat_addr = address; outstanding = 1;
    end
    if (done) begin done_cnt++; done_cyc = cyc; done_busy = busy; end
    wren_total += nw;
    if (full_row >= 0 && !full_trig_done && got_a[full_row].size() == 3) begin
      full_trig_done = 1; full_left = full_len;
    end
    if (w_read) begin w_addrs.push_back(w_address); w_pend = 1; end
    for (int i = 0; i < M; i++) if (w_a_wren[i]) w_wren++;
    if (w_b_wren) w_wren++;
    if (w_done) w_done_cnt++;
  end

  task automatic clear_obs();
    for (int i = 0; i < M; i++) got_a[i].delete();
    got_b.delete(); got_addr.delete(); hold_q.delete();
    done_cnt = 0; done_busy = 0; viol = 0; multi_wren = 0; stall_obs = 0; wren_total = 0;
    mcnt = 0; outstanding = 0; wr_left = 0; cur_row = 0; prev_stalled = 0;
    wait_addr_en = 0; wait_left = 0; full_row = -1; full_len = 0; full_left = 0;
    full_trig_done = 0;
  endtask

  task automatic fill_pattern(input logic [AW-1:0] b);
    logic [WW-1:0] w;
    for (int r = 0; r <= M; r++) begin
      for (int e = 0; e < N; e++) w[WW-1-DW*e -: DW] = DW'(N * r + e);
      mem[b + AW'(r)] = w;
    end
  endtask

  task automatic fill_random(input logic [AW-1:0] b);
    for (int r = 0; r <= M; r++) mem[b + AW'(r)] = {$urandom, $urandom};
  endtask

  task automatic launch(input string tag, input logic [AW-1:0] b, output int c0);
    @(negedge clk);
    start = 1'b1; base = b; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_read_after_start"}, read, 1);
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 4000 && done_cnt == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2;
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_busy_in_done"}, done_busy, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_protocol_viol"}, viol, 0);
    check({tag, "_multi_wren"}, multi_wren, 0);
  endtask

  task automatic compare_transfer(input string tag, input logic [AW-1:0] b);
    int errs;
    logic [WW-1:0] w;
    logic [DW-1:0] q [$];
    errs = 0;
    if (got_addr.size() != M + 1) errs = 100 + got_addr.size();
    else for (int r = 0; r <= M; r++) if (got_addr[r] != b + AW'(r)) errs++;
    check({tag, "_addr_errs"}, errs, 0);
    for (int r = 0; r <= M; r++) begin
      w = word_at(b + AW'(r));
      if (r < M) q = got_a[r]; else q = got_b;
      errs = 0;
      if (q.size() != N) errs = 100 + q.size();
      else for (int e = 0; e < N; e++) if (q[e] != w[WW-1-DW*e -: DW]) errs++;
      check($sformatf("%s_fifo%0d_errs", tag, r), errs, 0);
    end
  endtask

  initial begin
    int c0, errs, hold_exp;
    logic [AW-1:0] b;
    logic [WW-1:0] w;
    tbl[0] = '{32'h0000_0100, 1, -1, 0, -1, 0, 91, 0};
    tbl[1] = '{32'h0000_0100, 1,  2, 3, -1, 0, 94, 3};
    tbl[2] = '{32'h0000_0100, 1, -1, 0,  4, 5, 96, 5};
    tbl[3] = '{32'h0000_0000, 2, -1, 0, -1, 0, 100, 9};
    tbl[4] = '{32'hFFFF_FFFC, 3, -1, 0, -1, 0, 109, 18};

    rst = 1'b1; start = 1'b0; base = '0; waitreq = 1'b0; rdv = 1'b0; rdata = '0; b_full = 1'b0;
    for (int i = 0; i < M; i++) begin a_full[i] = 1'b0; w_a_full[i] = 1'b0; end
    w_start = 1'b0; w_base = '0; w_waitreq = 1'b0; w_rdv = 1'b0; w_rdata = '0; w_b_full = 1'b0;
    w_pend = 0; w_done_cnt = 0; w_wren = 0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    errs = 0;
    for (int i = 0; i < M; i++) if (a_wren[i]) errs++;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read", read, 0);
    check("rst_address", address, 0);
    check("rst_wdata", wdata, 0);
    check("rst_b_wren", b_wren, 0);
    check("rst_a_wren", errs, 0);
    @(negedge clk);
    rst = 1'b0;

    // table-driven loads
    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      clear_obs();
      if (i < 3) fill_pattern(tbl[i].base); else fill_random(tbl[i].base);
      lat = tbl[i].lat;
      wait_addr_en = (tbl[i].wait_row >= 0);
      wait_addr = tbl[i].base + AW'(tbl[i].wait_row);
      wait_left = tbl[i].wait_len;
      full_row = tbl[i].full_row;
      full_len = tbl[i].full_len;
      launch(tag, tbl[i].base, c0);
      wait_done(tag);
      compare_transfer(tag, tbl[i].base);
      check({tag, "_cycles"}, done_cyc - c0, tbl[i].exp_cycles);
      check({tag, "_stalls_seen"}, stall_obs, tbl[i].exp_stall);
`ifdef MMUL_LOADER_PERF_EN
      check({tag, "_stall_counter"}, stall_cycles, tbl[i].exp_stall);
`endif
      if (tbl[i].full_row >= 0) begin
        w = word_at(tbl[i].base + AW'(tbl[i].full_row));
        hold_exp = int'(w[WW-1-DW*3 -: DW]);
        errs = (hold_q.size() != tbl[i].full_len) ? 100 : 0;
        foreach (hold_q[k]) if (int'(hold_q[k]) != hold_exp) errs++;
        check({tag, "_wdata_held"}, errs, 0);
      end
    end

    // start while busy, then stray readdatavalid while idle
    clear_obs();
    fill_random(32'h200);
    lat = 1;
    launch("busy", 32'h200, c0);
    repeat (5) @(negedge clk);
    start = 1'b1; base = 32'h999;
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy");
    compare_transfer("busy", 32'h200);
    repeat (5) @(negedge clk);
    #2 inject_rdv = 1;
    repeat (20) @(negedge clk);
    #2;
    check("busy_total_wren", wren_total, (M + 1) * N);
    check("busy_done_total", done_cnt, 1);
    check("busy_reads", got_addr.size(), M + 1);
    check("idle_rdv_busy", busy, 0);

    // synchronous reset in the middle of row 3
    clear_obs();
    fill_random(32'h300);
    launch("rstmid", 32'h300, c0);
    for (int k = 0; k < 1000 && got_a[3].size() < 2; k++) @(negedge clk);
    check("rstmid_reached_row3", got_a[3].size() >= 2, 1);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    errs = 0;
    for (int i = 0; i < M; i++) if (a_wren[i]) errs++;
    check("rstmid_busy", busy, 0);
    check("rstmid_read", read, 0);
    check("rstmid_address", address, 0);
    check("rstmid_wdata", wdata, 0);
    check("rstmid_wren", errs + (b_wren ? 1 : 0), 0);
    clear_obs();
    inject_rdv = 1;
    @(negedge clk);
    #2 rst = 1'b0; inject_rdv = 1;
    repeat (20) @(negedge clk);
    #2;
    check("rstmid_no_wren", wren_total, 0);
    check("rstmid_no_done", done_cnt, 0);
    check("rstmid_no_read", got_addr.size(), 0);
    clear_obs();
    launch("rstnew", 32'h300, c0);
    wait_done("rstnew");
    compare_transfer("rstnew", 32'h300);

    // address wrap on the 4-bit instance
    w_addrs.delete(); w_done_cnt = 0; w_wren = 0;
    @(negedge clk);
    w_start = 1'b1; w_base = 4'hC;
    @(posedge clk); #1;
    w_start = 1'b0;
    for (int k = 0; k < 2000 && w_done_cnt == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2;
    errs = (w_addrs.size() != M + 1) ? 100 + w_addrs.size() : 0;
    if (errs == 0) for (int r = 0; r <= M; r++) if (w_addrs[r] != 4'(12 + r)) errs++;
    check("wrap_addr_errs", errs, 0);
    check("wrap_done", w_done_cnt, 1);
    check("wrap_wren", w_wren, (M + 1) * N);

    // randomized loads with stalls
    for (int t = 0; t < 4; t++) begin
      string tag;
      tag = $sformatf("rnd%0d", t);
      clear_obs();
      b = {$urandom};
      lat = $urandom_range(3, 1);
      rand_wait_pct = 30;
      rand_full_pct = 25;
      fill_random(b);
      launch(tag, b, c0);
      wait_done(tag);
      rand_wait_pct = 0;
      rand_full_pct = 0;
      compare_transfer(tag, b);
      check({tag, "_cycles"}, done_cyc - c0, (M + 1) * (N + 2) + 1 + stall_obs);
`ifdef MMUL_LOADER_PERF_EN
      check({tag, "_stall_counter"}, stall_cycles, stall_obs);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
